// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch front end.
package if_pkg;

    localparam logic [31:0] NOP_INST         = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // One buffered fetch result: the instruction and the address it came from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    // Force an address onto a word boundary.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with clear, used both for fetched {pc, inst} entries
// and for the pc tags of in-flight requests.
module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned      PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty_o = (r_count == '0);
    assign full_o  = (r_count == CNT_W'(DEPTH));
    assign count_o = r_count;
    assign head_o  = r_mem[r_rd_ptr];
    assign w_pop   = pop_i && !empty_o;
    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign w_push  = push_i && (!full_o || w_pop);

    // Storage array; contents are only visible through the count, so no reset.
    always_ff @(posedge clk_i) begin
        if (w_push && !clear_i && !rst_i) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    // Pointers and occupancy; reset and clear both empty the FIFO.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues requests over the
// req/gnt/rvalid handshake, buffers returned words and feeds IF/ID.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        flush_o
);

    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

    logic [31:0]      r_fetch_pc;
    logic [CNT_W-1:0] r_stale;

    fetch_entry_t     w_head;
    fetch_entry_t     w_push_entry;
    logic [31:0]      w_tag_head;
    logic [CNT_W-1:0] w_occ;
    logic [CNT_W-1:0] w_live;
    logic             w_buf_empty;
    logic             w_buf_full;
    logic             w_tag_empty;
    logic             w_tag_full;
    logic             w_room;
    logic             w_req;
    logic             w_fire;
    logic             w_resp_live;
    logic             w_valid;
    logic             w_pop;

    // Buffered plus in-flight requests are capped so a response always finds space.
    assign w_room = (32'(w_occ) + 32'(w_live) + 32'(r_stale)) < BUF_DEPTH;
    assign w_req  = !rst_i && !redirect_i && w_room && !w_buf_full && !w_tag_full;
    assign w_fire = w_req && imem_gnt_i;

    // Responses are in order: stale ones (from before a redirect) drain first.
    assign w_resp_live = !rst_i && !redirect_i && imem_rvalid_i
                         && (r_stale == '0) && !w_tag_empty;

    assign w_valid = !rst_i && !redirect_i && !w_buf_empty;
    assign w_pop   = w_valid && !stall_i;

    assign w_push_entry = '{pc: w_tag_head, inst: imem_rdata_i};

    assign imem_req_o  = w_req;
    assign imem_addr_o = rst_i ? 32'h0 : r_fetch_pc;
    assign pc_o        = w_valid ? w_head.pc : 32'h0;
    assign inst_o      = w_valid ? w_head.inst : NOP_INST;
    assign flush_o     = !w_valid;

    // Returned instructions waiting for IF/ID.
    fetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_buf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (redirect_i),
        .push_i  (w_resp_live),
        .data_i  (w_push_entry),
        .pop_i   (w_pop),
        .head_o  (w_head),
        .full_o  (w_buf_full),
        .empty_o (w_buf_empty),
        .count_o (w_occ)
    );

    // PC tags of granted requests whose responses are still wanted; its
    // occupancy is the live-request count.
    fetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (32)
    ) u_tag (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (redirect_i),
        .push_i  (w_fire),
        .data_i  (r_fetch_pc),
        .pop_i   (w_resp_live),
        .head_o  (w_tag_head),
        .full_o  (w_tag_full),
        .empty_o (w_tag_empty),
        .count_o (w_live)
    );

    // Fetch PC and stale-response bookkeeping; redirect outranks everything but reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fetch_pc <= RESET_PC;
            r_stale    <= '0;
        end else if (redirect_i) begin
            r_fetch_pc <= align_word(redirect_pc_i);
            // Every outstanding request becomes stale; a response landing this
            // cycle has already retired one of them.
            r_stale    <= r_stale + w_live - CNT_W'(imem_rvalid_i);
        end else begin
            if (w_fire) begin
                r_fetch_pc <= r_fetch_pc + PC_STEP;
            end
            if (imem_rvalid_i && (r_stale != '0)) begin
                r_stale <= r_stale - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with an in-order instruction-memory model
// and a scoreboard of expected {pc, inst} in fetch order.
module tb_if_fetch_unit;
    import if_pkg::*;

    logic        clk;
    logic        rst_i;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        flush_o;

    logic         rsp_en;
    logic [31:0]  gq[$];
    fetch_entry_t exp_q[$];
    logic [31:0]  exp_fetch_pc;
    int           n_checks;
    int           n_fail;

    if_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .pc_o          (pc_o),
        .inst_o        (inst_o),
        .flush_o       (flush_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] inst_fn(input logic [31:0] a);
        return {a[15:0], 16'hBEEF};
    endfunction

    // Memory model and scoreboard producer: grants are queued, answered in
    // order once rsp_en allows (earliest the cycle after the grant).
    always @(posedge clk) begin
        if (rst_i) begin
            gq.delete();
            exp_q.delete();
            imem_rvalid_i <= 1'b0;
            imem_rdata_i  <= 32'h0;
            exp_fetch_pc  <= 32'h0;
        end else begin
            if (imem_req_o && imem_gnt_i) begin
                gq.push_back(imem_addr_o);
            end
            if (rsp_en && gq.size() != 0) begin
                imem_rvalid_i <= 1'b1;
                imem_rdata_i  <= inst_fn(gq[0]);
                void'(gq.pop_front());
            end else begin
                imem_rvalid_i <= 1'b0;
            end
            if (redirect_i) begin
                exp_q.delete();
                exp_fetch_pc <= redirect_pc_i & ~32'h3;
            end else if (imem_req_o && imem_gnt_i) begin
                exp_q.push_back('{pc: exp_fetch_pc, inst: inst_fn(exp_fetch_pc)});
                exp_fetch_pc <= exp_fetch_pc + 32'd4;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Checks that hold on every cycle; consumes the scoreboard head when IF/ID takes it.
    task automatic auto_check();
        if (rst_i) begin
            chk("rst_req", {31'h0, imem_req_o}, 32'd0);
            chk("rst_flush", {31'h0, flush_o}, 32'd1);
            chk("rst_pc", pc_o, 32'h0);
            chk("rst_inst", inst_o, 32'h0);
        end else begin
            if (redirect_i) begin
                chk("redir_flush", {31'h0, flush_o}, 32'd1);
                chk("redir_req", {31'h0, imem_req_o}, 32'd0);
            end
            chk("fetch_addr", imem_addr_o, exp_fetch_pc);
            if (!flush_o) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_valid", {31'h0, flush_o}, 32'd1);
                end else begin
                    chk("sb_pc", pc_o, exp_q[0].pc);
                    chk("sb_inst", inst_o, exp_q[0].inst);
                    if (!stall_i) begin
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    endtask

    task automatic step(input logic rst, input logic stall, input logic redir,
                        input logic [31:0] rpc, input logic gnt);
        @(negedge clk);
        rst_i         = rst;
        stall_i       = stall;
        redirect_i    = redir;
        redirect_pc_i = rpc;
        imem_gnt_i    = gnt;
        #1;
        auto_check();
    endtask

    task automatic do_reset();
        rsp_en = 1'b1;
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    // Run until a valid instruction is shown (bounded) and check it.
    task automatic wait_valid(input string tag, input logic [31:0] pc_exp);
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < 16 && !seen; c++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
            if (!flush_o) begin
                seen = 1'b1;
                chk({tag, "_pc"}, pc_o, pc_exp);
                chk({tag, "_inst"}, inst_o, inst_fn(pc_exp));
            end
        end
        chk({tag, "_seen"}, {31'h0, seen}, 32'd1);
    endtask

    initial begin
        logic [31:0] got [3];
        int          nvalid;
        int          first;

        n_checks      = 0;
        n_fail        = 0;
        rst_i         = 1'b1;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        imem_gnt_i    = 1'b0;
        rsp_en        = 1'b1;
        do_reset();

        // Streaming from reset with 1-cycle memory.
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("t1_req0", {31'h0, imem_req_o}, 32'd1);
        chk("t1_addr0", imem_addr_o, 32'h0);
        nvalid = 0;
        first  = -1;
        for (int c = 1; c < 16 && nvalid < 3; c++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
            if (!flush_o) begin
                if (nvalid == 0) first = c;
                got[nvalid] = pc_o;
                nvalid++;
            end
        end
        chk("t1_nvalid", nvalid, 3);
        chk("t1_latency", first, 2);
        chk("t1_pc0", got[0], 32'h0);
        chk("t1_pc1", got[1], 32'h4);
        chk("t1_pc2", got[2], 32'h8);

        // No grant: bubbles only, fetch PC parked at reset address.
        do_reset();
        for (int c = 0; c < 4; c++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            chk("t2_flush", {31'h0, flush_o}, 32'd1);
            chk("t2_inst", inst_o, 32'h0);
            chk("t2_addr", imem_addr_o, 32'h0);
        end

        // Stall holds the head and throttles requests at the cap.
        do_reset();
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
            chk("t3_pc", pc_o, 32'h0);
            chk("t3_inst", inst_o, inst_fn(32'h0));
            chk("t3_flush", {31'h0, flush_o}, 32'd0);
            chk("t3_req", {31'h0, imem_req_o}, 32'd0);
        end
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("t3_rel_pc", pc_o, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("t3_next_pc", pc_o, 32'h4);
        chk("t3_next_flush", {31'h0, flush_o}, 32'd0);

        // Redirect with 0x8 and 0xC in flight: both responses must be dropped.
        do_reset();
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        rsp_en = 1'b0;
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("t4_addr8", imem_addr_o, 32'h8);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("t4_addrC", imem_addr_o, 32'hC);
        step(1'b0, 1'b0, 1'b1, 32'h100, 1'b1);
        chk("t4_flush", {31'h0, flush_o}, 32'd1);
        rsp_en = 1'b1;
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("t4_addr", imem_addr_o, 32'h100);
        wait_valid("t4", 32'h100);

        // Redirect together with stall, unaligned target.
        do_reset();
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 32'h103, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("t5_addr", imem_addr_o, 32'h100);
        chk("t5_flush", {31'h0, flush_o}, 32'd1);
        wait_valid("t5", 32'h100);

        // Reset in the middle of a stream.
        for (int c = 0; c < 4; c++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        end
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("t6_flush", {31'h0, flush_o}, 32'd1);
        chk("t6_pc", pc_o, 32'h0);
        chk("t6_inst", inst_o, 32'h0);
        chk("t6_req", {31'h0, imem_req_o}, 32'd1);
        chk("t6_addr", imem_addr_o, 32'h0);
        wait_valid("t6", 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
